// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int BYTE_W = 8;

    // Number of byte lanes in one instruction word.
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic [7:0]            s_data;
    logic                  s_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembly. byte 0 lands in the LSBs.
// full is a lookahead: it is high while the next accepted byte completes
// the word, so the FSM can leave RECV on the same edge that takes it.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  clr,
    input  logic                  byte_en,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  full
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0] byte_cnt;

    assign full = (byte_cnt == IDX_W'(BPW - 1));

    // Lane pointer and assembly register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
            word_out <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (byte_en) begin
            for (int i = 0; i < BPW; i++) begin
                if (byte_cnt == IDX_W'(i)) begin
                    word_out[i*BYTE_W +: BYTE_W] <= byte_in;
                end
            end
            byte_cnt <= full ? '0 : byte_cnt + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream and holds the
// core in reset until the whole program has been written.
//
// state | meaning
// IDLE  | no load since reset; core held in reset
// RECV  | collecting bytes of the current word (s_ready=1)
// WRITE | one-cycle memory write of the assembled word
// DONE  | load complete; core released
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] len_words,
    imem_loader_if.master       bus,
    output logic                core_reset_n,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_t         state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH:0]   word_next;
    logic                  s_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  idle_like;
    logic                  start_ok;
    logic                  byte_en;
    logic                  clr;
    logic                  full;
    logic [DATA_WIDTH-1:0] word_out;
    logic [DATA_WIDTH-1:0] word_merged;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign start_ok  = idle_like && start && (len_words <= MAX_LEN) && (len_words != '0);
    assign byte_en   = (state == RECV) && s_ready_q && bus.s_valid;
    assign clr       = start_ok || (state == WRITE);
    assign word_next = {1'b0, word_cnt} + (ADDR_WIDTH+1)'(1);

    // The last byte is still on s_data when the write is registered, so
    // splice it into the top lane here instead of waiting a cycle for it.
    always_comb begin
        word_merged = word_out;
        word_merged[DATA_WIDTH-1 -: BYTE_W] = bus.s_data;
    end

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .clr      (clr),
        .byte_en  (byte_en),
        .byte_in  (bus.s_data),
        .word_out (word_out),
        .full     (full)
    );

    // Load sequencing FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            len_q        <= '0;
            word_cnt     <= '0;
            s_ready_q    <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_words > MAX_LEN) begin
                            err <= 1'b1;
                        end else if (len_words == '0) begin
                            err          <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                            state        <= DONE;
                        end else begin
                            len_q        <= len_words;
                            word_cnt     <= '0;
                            err          <= 1'b0;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            core_reset_n <= 1'b0;
                            s_ready_q    <= 1'b1;
                            state        <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (byte_en && full) begin
                        s_ready_q <= 1'b0;
                        we_q      <= 1'b1;
                        waddr_q   <= word_cnt;
                        wdata_q   <= word_merged;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    we_q     <= 1'b0;
                    word_cnt <= word_cnt + ADDR_WIDTH'(1);
                    if (word_next == len_q) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        core_reset_n <= 1'b1;
                        state        <= DONE;
                    end else begin
                        s_ready_q <= 1'b1;
                        state     <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the single-cycle core reads through iaddr/idata.
- Accepts a byte stream through a valid/ready handshake and packs the bytes little-endian into DATA_WIDTH-bit words.
- Writes each packed word into instruction memory at consecutive addresses starting from 0.
- Holds the core in reset until the whole program is loaded, then releases it. Replaces loading the program from a file at elaboration.

Parameters:
ADDR_WIDTH, 10, instruction memory address width in words
DATA_WIDTH, 32, instruction word width; must be a multiple of 8
BYTES_PER_WORD, DATA_WIDTH/8, derived; not overridden

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a load
len_words  input  ADDR_WIDTH+1  number of words to load; sampled on start
s_valid  input  1  byte-stream valid
s_data  input  8  byte-stream data
s_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable
imem_waddr  output  ADDR_WIDTH  word write address
imem_wdata  output  DATA_WIDTH  word write data
core_reset_n  output  1  active-low reset to the core; 1 only when the load is complete
busy  output  1  a load is in progress
done  output  1  the last load completed
err  output  1  the last start was rejected because len_words was too large

Behaviour:
- All outputs are registered. RESET_N low forces asynchronously: state=IDLE, s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_reset_n=0, busy=0, done=0, err=0, word_cnt=0, byte_cnt=0.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 and len_words > 2**ADDR_WIDTH: err<=1, stay in IDLE, no writes.
  - start=1 and len_words==0: go to DONE, err<=0.
  - start=1 otherwise: latch len_words, clear word_cnt and byte_cnt, err<=0, busy<=1, go to RECV.
- RECV:
  - s_ready=1 for the whole state.
  - A byte is accepted only on a cycle with s_valid & s_ready. It goes to bits [8*byte_cnt+7 : 8*byte_cnt] of the assembly register (byte 0 = LSB), and byte_cnt increments.
  - Accepting byte BYTES_PER_WORD-1 moves the FSM to WRITE and drops s_ready on the next cycle.
  - If s_valid is low, the FSM waits indefinitely; there is no timeout.
- WRITE:
  - Lasts exactly one cycle, with imem_we=1, imem_waddr=word_cnt, imem_wdata=assembled word, s_ready=0.
  - The next cycle has imem_we=0 and word_cnt+1.
  - If word_cnt+1==len, go to DONE; otherwise byte_cnt=0 and go back to RECV.
- DONE:
  - busy=0, done=1, core_reset_n=1. imem_waddr and imem_wdata hold their last values.
  - start in DONE re-runs the same IDLE checks. On acceptance, done and core_reset_n drop to 0 the next cycle, so the core is held in reset for the whole reload.
- start while in RECV or WRITE is ignored.
- Throughput: at most 1 word per BYTES_PER_WORD+1 cycles.
- Latency: start to first s_ready = 1 cycle; last write cycle to core_reset_n=1 = 1 cycle.
- Address wrap: word_cnt tops out at 2**ADDR_WIDTH-1 because len is bounded, so imem_waddr never wraps.
- Reset during a load: memory contents are undefined and the core stays in reset until a new load completes.

Decomposition:
- Shared package loader_pkg holds:
  - typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t
  - localparam BYTE_W = 8
  - a function bytes_per_word(DATA_WIDTH)
- Sub-module byte_packer does byte-to-word assembly, with ports CLK, RESET_N, clr, byte_en, byte_in, word_out and full.
- imem_loader contains the FSM, counters and output registers.

Test Plan:
1. Single word: start with len_words=1, bytes 0x13,0x00,0x00,0x00 -> one cycle of imem_we with imem_waddr=0 and imem_wdata=0x00000013; done and core_reset_n go to 1 on the next cycle.
2. Three words with s_valid gaps (random 0-3 idle cycles): bytes for 0x00500093, 0x00100113, 0x002081B3 -> writes to addresses 0,1,2 with exactly those words; s_ready=0 in every WRITE cycle; no byte is lost or duplicated.
3. len_words=0 -> DONE one cycle after start, no imem_we pulse, core_reset_n=1.
4. len_words=1025 with ADDR_WIDTH=10 -> err=1, busy=0, no writes, core_reset_n stays 0. A following start with len_words=1024 clears err and writes to addresses 0..1023.
5. RESET_N pulsed low after 6 bytes of a len_words=4 load -> all outputs go to their reset values immediately. A restart with len_words=2 writes to addresses 0 and 1 only.
6. start pulsed during RECV -> ignored. start in DONE -> core_reset_n=0 on the next cycle, reload completes, core_reset_n returns to 1.
